fetch_queue: RTL and testbench

Instruction fetch queue between the fetch stage and the instruction decoder. Buffers up to DEPTH fetched instruction words with their PC and fetch-fault flag, decoupling instruction-memory latency from decode stalls. Uses valid/ready handshakes on both sides and supports a single-cycle flush for branch, trap or MRET/SRET redirects. `out_instr` drives the decoder's 32-bit `instruction` input directly.

---
 rtl/fetch_queue_pkg.sv | 29 ++
 rtl/fetch_queue_mem.sv | 23 ++
 rtl/fetch_queue.sv | 126 ++++++++++++
 tb/tb_fetch_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
// The optional same-cycle bypass is controlled by the RV_FETCHQ_BYPASS_EN macro in fetch_queue.sv.
package fetch_queue_pkg;

  localparam int          FqXlen       = 32;
  localparam int          FqDepth      = 4;
  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_BOTH,
    OP_CLEAR
  } fq_op_e;

  // A clear (reset or redirect) overrides any handshake in the same cycle.
  function automatic fq_op_e fq_classify(input logic clear, input logic doWrite,
                                         input logic doRead);
    fq_op_e op;
    op = OP_IDLE;
    if (clear)                 op = OP_CLEAR;
    else if (doWrite && doRead) op = OP_BOTH;
    else if (doWrite)           op = OP_PUSH;
    else if (doRead)            op = OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one write port, one asynchronous read port.
// Contents are deliberately not reset; occupancy tracking lives in fetch_queue.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode with valid/ready on both sides and redirect flush.
// Define RV_FETCHQ_BYPASS_EN to let a word reach the decoder in the same cycle when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int XLEN  = FqXlen,
  parameter int DEPTH = FqDepth
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     in_fault,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_fault,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;
  localparam int EntW = XLEN + 33;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic [PtrW-1:0] rdPtr_q, rdPtr_d;
  logic [PtrW-1:0] wrPtr_q, wrPtr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            active;
  logic            queueValid;
  logic            bypassActive;
  logic            push;
  logic            doWrite;
  logic            doRead;
  logic [EntW-1:0] wrEntry;
  logic [EntW-1:0] rdEntry;
  fq_op_e          op;

  assign active     = !reset && !flush;
  assign in_ready   = active && (count_q != FullCount);
  assign queueValid = active && (count_q != '0);

`ifdef RV_FETCHQ_BYPASS_EN
  assign bypassActive = active && (count_q == '0) && in_valid;
`else
  assign bypassActive = 1'b0;
`endif

  assign out_valid = queueValid || bypassActive;
  assign push      = in_valid && in_ready;
  // A bypassed word that the decoder takes right away never enters storage.
  assign doWrite   = push && !(bypassActive && out_ready);
  assign doRead    = queueValid && out_ready;
  assign wrEntry   = {in_pc, in_instr, in_fault};
  assign count     = count_q;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EntW)
  ) u_mem (
    .clk   (clk),
    .we    (doWrite),
    .waddr (wrPtr_q),
    .wdata (wrEntry),
    .raddr (rdPtr_q),
    .rdata (rdEntry)
  );

  always_comb begin
    out_pc    = '0;
    out_instr = RV_NOP_INSTR;
    out_fault = 1'b0;
    if (queueValid) begin
      {out_pc, out_instr, out_fault} = rdEntry;
    end else if (bypassActive) begin
      out_pc    = in_pc;
      out_instr = in_instr;
      out_fault = in_fault;
    end
  end

  always_comb begin
    op      = fq_classify(!active, doWrite, doRead);
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    case (op)
      OP_CLEAR: begin
        rdPtr_d = '0;
        wrPtr_d = '0;
        count_d = '0;
      end
      OP_PUSH: begin
        wrPtr_d = wrPtr_q + PtrW'(1);
        count_d = count_q + CntW'(1);
      end
      OP_POP: begin
        rdPtr_d = rdPtr_q + PtrW'(1);
        count_d = count_q - CntW'(1);
      end
      OP_BOTH: begin
        wrPtr_d = wrPtr_q + PtrW'(1);
        rdPtr_d = rdPtr_q + PtrW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (XLEN=32, DEPTH=4); expectations follow the bypass macro if it is defined.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_fault;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  fetch_queue #(
    .XLEN  (32),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_fault  (in_fault),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_fault (out_fault),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                               input logic fault, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    in_fault  = fault;
    out_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_count", count, 0);

    reset = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("post_rst_out_valid", out_valid, 0);
    checkOutput("post_rst_out_pc", out_pc, 0);
    checkOutput("post_rst_out_instr", out_instr, 32'h13);
    checkOutput("post_rst_out_fault", out_fault, 0);

    // Single push, one-cycle latency
    applyStimulus(1'b1, 32'h1000, 32'h93, 1'b0, 1'b0);
`ifdef RV_FETCHQ_BYPASS_EN
    checkOutput("t1_same_cycle_valid", out_valid, 1);
`else
    checkOutput("t1_same_cycle_valid", out_valid, 0);
`endif
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("t1_out_valid", out_valid, 1);
    checkOutput("t1_out_pc", out_pc, 32'h1000);
    checkOutput("t1_out_instr", out_instr, 32'h93);
    checkOutput("t1_count", count, 1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("t1_drained", count, 0);

    // Fill to DEPTH, then pop once while fetch keeps offering a word
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("t2_full_count", count, 4);
    checkOutput("t2_full_in_ready", in_ready, 0);
    applyStimulus(1'b1, 32'h900, 32'h900, 1'b0, 1'b1);
    checkOutput("t2_full_in_ready_popping", in_ready, 0);
    checkOutput("t2_head_pc", out_pc, 32'h100);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("t2_after_pop_count", count, 3);
    checkOutput("t2_after_pop_in_ready", in_ready, 1);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      checkOutput("t2_drain_pc", out_pc, 32'h100 + 32'(4 * i));
      checkOutput("t2_drain_instr", out_instr, 32'hA0 + 32'(i));
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("t2_empty", count, 0);

    // Sustained push and pop across pointer wrap
    applyStimulus(1'b1, 32'h0, 32'h5000, 1'b0, 1'b0);
    tick();
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 32'(4 * i), 32'h5000 + 32'(i), 1'b0, 1'b1);
      checkOutput("t3_order_pc", out_pc, 32'(4 * (i - 1)));
      tick();
      checkOutput("t3_count", count, 1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("t3_last_pc", out_pc, 32'h40);
    checkOutput("t3_last_instr", out_instr, 32'h5010);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("t3_empty", count, 0);

    // Flush with a word presented the same cycle
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h300 + 32'(4 * i), 32'h1, 1'b0, 1'b0);
      tick();
    end
    flush = 1'b1;
    applyStimulus(1'b1, 32'h400, 32'h2, 1'b0, 1'b0);
    checkOutput("t4_flush_out_valid", out_valid, 0);
    checkOutput("t4_flush_in_ready", in_ready, 0);
    checkOutput("t4_flush_out_instr", out_instr, 32'h13);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("t4_count", count, 0);
    checkOutput("t4_out_instr", out_instr, 32'h13);
    checkOutput("t4_out_valid", out_valid, 0);
    checkOutput("t4_in_ready", in_ready, 1);
    tick();
    checkOutput("t4_dropped", count, 0);

    // Faulted entry followed by a clean one
    applyStimulus(1'b1, 32'h2000, 32'h3, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h2004, 32'h4, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("t5_fault", out_fault, 1);
    checkOutput("t5_fault_pc", out_pc, 32'h2000);
    tick();
    checkOutput("t5_next_fault", out_fault, 0);
    checkOutput("t5_next_pc", out_pc, 32'h2004);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("t5_empty", count, 0);

    // Empty queue with both sides ready
    applyStimulus(1'b1, 32'h3000, 32'h33, 1'b0, 1'b1);
`ifdef RV_FETCHQ_BYPASS_EN
    checkOutput("t6_bypass_valid", out_valid, 1);
    checkOutput("t6_bypass_pc", out_pc, 32'h3000);
    checkOutput("t6_bypass_instr", out_instr, 32'h33);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("t6_bypass_count", count, 0);
`else
    checkOutput("t6_no_bypass_valid", out_valid, 0);
    checkOutput("t6_no_bypass_instr", out_instr, 32'h13);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("t6_written_count", count, 1);
    checkOutput("t6_written_pc", out_pc, 32'h3000);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("t6_drained", count, 0);
`endif

    // Reset mid-operation
    applyStimulus(1'b1, 32'h6000, 32'h5, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("t7_pre_reset_count", count, 2);
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("t7_count", count, 0);
    checkOutput("t7_in_ready", in_ready, 1);
    checkOutput("t7_out_valid", out_valid, 0);
    checkOutput("t7_out_pc", out_pc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
